sw_pad_io_bridge: RTL and testbench



---
 rtl/sw_pad_io_bridge_pkg.sv | 32 +++
 rtl/sw_pad_io_bridge_if.sv | 45 ++++
 rtl/sw_pad_io_bridge_serializer.sv | 86 ++++++++
 rtl/sw_pad_io_bridge.sv | 181 ++++++++++++++++++
 tb/tb_sw_pad_io_bridge.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_pad_io_bridge_pkg.sv
// Shared types and elaboration helpers for the Smith-Waterman pad I/O bridge.
// Holds the bridge state encoding, beat-count derivations and a parity helper.
package sw_io_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Input beats needed to assemble one full sequence.
  function automatic int calc_beats(input int seq_len, input int base_w, input int in_w);
    return (seq_len * base_w) / in_w;
  endfunction

  // Output chunks needed to carry one score, rounding up.
  function automatic int calc_out_beats(input int score_w, input int out_w);
    return (score_w + out_w - 1) / out_w;
  endfunction

  // Counter width able to index n items; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even parity of a zero-padded vector; padding does not change the result.
  function automatic logic even_parity(input logic [255:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sw_pad_io_bridge_if.sv
// Pad/core signal bundle for sw_pad_io_bridge.
// master = pad ring and core side, slave = the bridge itself.
interface sw_pad_io_bridge_if #(
  parameter int IN_W    = 8,
  parameter int BASE_W  = 2,
  parameter int SEQ_LEN = 16,
  parameter int SCORE_W = 7,
  parameter int OUT_W   = 4
);

  logic                        pad_valid;
  logic [IN_W-1:0]             pad_query;
  logic [IN_W-1:0]             pad_db;
  logic                        pad_parity;
  logic                        pad_busy;
  logic [SEQ_LEN*BASE_W-1:0]   core_query;
  logic [SEQ_LEN*BASE_W-1:0]   core_db;
  logic                        core_ready;
  logic                        core_start;
  logic                        core_score_valid;
  logic [SCORE_W-1:0]          core_score;
  logic                        pad_out_valid;
  logic [OUT_W-1:0]            pad_out_data;
  logic                        pad_out_last;
  logic                        err_clr;
  logic                        err_overrun;
  logic                        err_parity;

  modport master (
    output pad_valid, pad_query, pad_db, pad_parity,
    output core_ready, core_score_valid, core_score, err_clr,
    input  pad_busy, core_query, core_db, core_start,
    input  pad_out_valid, pad_out_data, pad_out_last,
    input  err_overrun, err_parity
  );

  modport slave (
    input  pad_valid, pad_query, pad_db, pad_parity,
    input  core_ready, core_score_valid, core_score, err_clr,
    output pad_busy, core_query, core_db, core_start,
    output pad_out_valid, pad_out_data, pad_out_last,
    output err_overrun, err_parity
  );

endinterface

// File: rtl/sw_pad_io_bridge_serializer.sv
// sw_score_serializer: shifts a captured score out MSB chunk first, one chunk per cycle,
// with registered valid/last strobes. Loading happens on the capture pulse.
module sw_score_serializer
  import sw_io_pkg::*;
#(
  parameter int SCORE_W = 7,
  parameter int OUT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_capture,
  input  logic [SCORE_W-1:0] i_score,
  output logic               o_valid,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_last
);

  localparam int OUT_BEATS = calc_out_beats(SCORE_W, OUT_W);
  localparam int SH_W      = OUT_BEATS * OUT_W;
  localparam int CW        = cnt_w(OUT_BEATS);

  logic [SH_W-1:0]  w_ext;
  logic [SH_W-1:0]  r_shift;
  logic [SH_W-1:0]  w_shift_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] w_data_nxt;
  logic             r_last;
  logic             w_last_nxt;

  assign w_ext = SH_W'(i_score);

  // Next chunk selection: load on capture, advance while valid, idle to zero after last.
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    if (i_capture) begin
      w_data_nxt  = w_ext[SH_W-1 -: OUT_W];
      w_shift_nxt = w_ext << OUT_W;
      w_cnt_nxt   = {CW{1'b0}};
      w_valid_nxt = 1'b1;
      w_last_nxt  = (OUT_BEATS == 1);
    end else if (r_valid && r_last) begin
      w_data_nxt  = {OUT_W{1'b0}};
      w_shift_nxt = {SH_W{1'b0}};
      w_cnt_nxt   = {CW{1'b0}};
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
    end else if (r_valid) begin
      w_data_nxt  = r_shift[SH_W-1 -: OUT_W];
      w_shift_nxt = r_shift << OUT_W;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_last_nxt  = ((r_cnt + CW'(1)) == CW'(OUT_BEATS - 1));
    end else begin
      w_valid_nxt = 1'b0;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= {SH_W{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_valid <= 1'b0;
      r_data  <= {OUT_W{1'b0}};
      r_last  <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/sw_pad_io_bridge.sv
// sw_pad_io_bridge: assembles pad beats into core sequences, launches the core and
// serialises the score back to the pads. Optional beat parity check: SW_IO_PARITY_EN.
module sw_pad_io_bridge
  import sw_io_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int BASE_W  = 2,
  parameter int SEQ_LEN = 16,
  parameter int SCORE_W = 7,
  parameter int OUT_W   = 4
) (
  input logic               clk,
  input logic               rst,
  sw_pad_io_bridge_if.slave bus
);

  localparam int VEC_W = SEQ_LEN * BASE_W;
  localparam int BEATS = calc_beats(SEQ_LEN, BASE_W, IN_W);
  localparam int BCW   = cnt_w(BEATS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BCW-1:0]   r_beat;
  logic [BCW-1:0]   w_beat_nxt;
  logic [VEC_W-1:0] r_query;
  logic [VEC_W-1:0] w_query_nxt;
  logic [VEC_W-1:0] r_db;
  logic [VEC_W-1:0] w_db_nxt;
  logic             r_start;
  logic             w_start_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_err_ovr;
  logic             w_err_ovr_nxt;
  logic             r_err_par;
  logic             w_err_par_nxt;
  logic             w_capture;
  logic             w_par_bad;
  logic             w_par_set;
  logic             w_ovr_set;
  logic             w_out_valid;
  logic [OUT_W-1:0] w_out_data;
  logic             w_out_last;

`ifdef SW_IO_PARITY_EN
  assign w_par_bad = (bus.pad_parity != even_parity(256'({bus.pad_query, bus.pad_db})));
`else
  assign w_par_bad = 1'b0;
`endif

  // Main FSM next-state and registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_query_nxt = r_query;
    w_db_nxt    = r_db;
    w_start_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_capture   = 1'b0;
    w_par_set   = 1'b0;
    case (r_state)
      LOAD: begin
        w_busy_nxt = 1'b0;
        if (bus.pad_valid && w_par_bad) begin
          // A corrupt beat invalidates the whole partial sequence.
          w_beat_nxt = {BCW{1'b0}};
          w_par_set  = 1'b1;
        end else if (bus.pad_valid) begin
          w_query_nxt = (r_query << IN_W) | VEC_W'(bus.pad_query);
          w_db_nxt    = (r_db << IN_W) | VEC_W'(bus.pad_db);
          if (r_beat == BCW'(BEATS - 1)) begin
            w_beat_nxt  = {BCW{1'b0}};
            w_state_nxt = ARMED;
            w_busy_nxt  = 1'b1;
          end else begin
            w_beat_nxt = r_beat + BCW'(1);
          end
        end else begin
          w_beat_nxt = r_beat;
        end
      end
      ARMED: begin
        w_busy_nxt = 1'b1;
        if (bus.core_ready) begin
          w_start_nxt = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = ARMED;
        end
      end
      RUN: begin
        if (bus.core_score_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        // The serializer's last flag marks the final chunk on the pads this cycle.
        if (w_out_last) begin
          w_state_nxt = LOAD;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_beat_nxt  = {BCW{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Sticky error flags: a new event beats a simultaneous clear.
  always_comb begin
    w_ovr_set = bus.pad_valid && (r_state != LOAD);
    if (w_ovr_set) begin
      w_err_ovr_nxt = 1'b1;
    end else if (bus.err_clr) begin
      w_err_ovr_nxt = 1'b0;
    end else begin
      w_err_ovr_nxt = r_err_ovr;
    end
    if (w_par_set) begin
      w_err_par_nxt = 1'b1;
    end else if (bus.err_clr) begin
      w_err_par_nxt = 1'b0;
    end else begin
      w_err_par_nxt = r_err_par;
    end
  end

  // Main state, vectors, strobes and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD;
      r_beat    <= {BCW{1'b0}};
      r_query   <= {VEC_W{1'b0}};
      r_db      <= {VEC_W{1'b0}};
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_err_ovr <= 1'b0;
      r_err_par <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_query   <= w_query_nxt;
      r_db      <= w_db_nxt;
      r_start   <= w_start_nxt;
      r_busy    <= w_busy_nxt;
      r_err_ovr <= w_err_ovr_nxt;
      r_err_par <= w_err_par_nxt;
    end
  end

  sw_score_serializer #(
    .SCORE_W (SCORE_W),
    .OUT_W   (OUT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_score   (bus.core_score),
    .o_valid   (w_out_valid),
    .o_data    (w_out_data),
    .o_last    (w_out_last)
  );

  assign bus.pad_busy      = r_busy;
  assign bus.core_query    = r_query;
  assign bus.core_db       = r_db;
  assign bus.core_start    = r_start;
  assign bus.pad_out_valid = w_out_valid;
  assign bus.pad_out_data  = w_out_data;
  assign bus.pad_out_last  = w_out_last;
  assign bus.err_overrun   = r_err_ovr;
  assign bus.err_parity    = r_err_par;

endmodule

// File: tb/tb_sw_pad_io_bridge.sv
// Self-checking bench for sw_pad_io_bridge at default parameters: a vector table,
// hand-written corner sequences and randomized transactions against a reference model.
module tb_sw_pad_io_bridge;

  localparam int IN_W    = 8;
  localparam int BASE_W  = 2;
  localparam int SEQ_LEN = 16;
  localparam int SCORE_W = 7;
  localparam int OUT_W   = 4;
  localparam int OB      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cnt_start = 0;
  int   cnt_valid = 0;
  int   cnt_last  = 0;

  sw_pad_io_bridge_if #(.IN_W(IN_W), .BASE_W(BASE_W), .SEQ_LEN(SEQ_LEN),
                        .SCORE_W(SCORE_W), .OUT_W(OUT_W)) bus_if ();

  sw_pad_io_bridge #(.IN_W(IN_W), .BASE_W(BASE_W), .SEQ_LEN(SEQ_LEN),
                     .SCORE_W(SCORE_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Strobe activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    cnt_start += int'(bus_if.core_start);
    cnt_valid += int'(bus_if.pad_out_valid);
    cnt_last  += int'(bus_if.pad_out_last);
  end

  typedef struct {
    logic [31:0] query;
    logic [31:0] db;
    logic [6:0]  score;
    int          hold;
    logic [31:0] exp_q;
    logic [31:0] exp_db;
    logic [7:0]  exp_chunks;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: score chunks MSB first, by plain base-2^OUT_W digit extraction.
  function automatic logic [7:0] model_chunks(input int s);
    logic [7:0] r;
    int base;
    r = 8'h00;
    base = 1 << OUT_W;
    for (int i = 0; i < OB; i++) r = (r << OUT_W) | 8'((s / (base ** (OB - 1 - i))) % base);
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  64'(bus_if.pad_busy), 64'd0);
    check({tag, "_start"}, 64'(bus_if.core_start), 64'd0);
    check({tag, "_query"}, 64'(bus_if.core_query), 64'd0);
    check({tag, "_db"},    64'(bus_if.core_db), 64'd0);
    check({tag, "_oval"},  64'(bus_if.pad_out_valid), 64'd0);
    check({tag, "_odata"}, 64'(bus_if.pad_out_data), 64'd0);
    check({tag, "_olast"}, 64'(bus_if.pad_out_last), 64'd0);
    check({tag, "_eovr"},  64'(bus_if.err_overrun), 64'd0);
    check({tag, "_epar"},  64'(bus_if.err_parity), 64'd0);
  endtask

  task automatic send_beat(input logic [7:0] q, input logic [7:0] d, input logic bad);
    bus_if.pad_valid  = 1'b1;
    bus_if.pad_query  = q;
    bus_if.pad_db     = d;
    bus_if.pad_parity = (^{q, d}) ^ bad;
    tick();
    bus_if.pad_valid  = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] q, input logic [31:0] d);
    for (int i = 0; i < 4; i++) send_beat(q[31-8*i -: 8], d[31-8*i -: 8], 1'b0);
  endtask

  task automatic launch(input logic [31:0] eq, input logic [31:0] ed, input int hold, input bit noise);
    int s0;
    int v0;
    check("armed_busy", 64'(bus_if.pad_busy), 64'd1);
    check("armed_query", 64'(bus_if.core_query), 64'(eq));
    check("armed_db", 64'(bus_if.core_db), 64'(ed));
    check("armed_no_start", 64'(bus_if.core_start), 64'd0);
    if (hold > 0) begin
      s0 = cnt_start;
      v0 = cnt_valid;
      bus_if.core_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        if (noise) begin
          bus_if.core_score_valid = 1'($urandom_range(0, 1));
          bus_if.core_score = 7'($urandom);
        end
        tick();
      end
      bus_if.core_score_valid = 1'b0;
      check("hold_start_count", 64'(cnt_start - s0), 64'd0);
      check("hold_valid_count", 64'(cnt_valid - v0), 64'd0);
    end
    bus_if.core_ready = 1'b1;
    tick();
    check("start_pulse", 64'(bus_if.core_start), 64'd1);
    tick();
    check("start_single", 64'(bus_if.core_start), 64'd0);
  endtask

  task automatic drain(input logic [6:0] s, input logic [7:0] ec, input int pre);
    int v0;
    v0 = cnt_valid;
    for (int i = 0; i < pre; i++) tick();
    check("run_no_valid", 64'(cnt_valid - v0), 64'd0);
    bus_if.core_score = s;
    bus_if.core_score_valid = 1'b1;
    tick();
    bus_if.core_score_valid = 1'b0;
    bus_if.core_score = 7'($urandom);
    for (int i = 0; i < OB; i++) begin
      check("chunk_valid", 64'(bus_if.pad_out_valid), 64'd1);
      check("chunk_data", 64'(bus_if.pad_out_data), 64'(ec[(OB-1-i)*OUT_W +: OUT_W]));
      check("chunk_last", 64'(bus_if.pad_out_last), 64'(i == OB - 1));
      check("chunk_busy", 64'(bus_if.pad_busy), 64'd1);
      tick();
    end
    check("post_valid", 64'(bus_if.pad_out_valid), 64'd0);
    check("post_last", 64'(bus_if.pad_out_last), 64'd0);
    check("post_busy", 64'(bus_if.pad_busy), 64'd0);
  endtask

  initial begin
    logic [31:0] eq;
    logic [31:0] ed;
    logic [7:0]  bq;
    logic [7:0]  bd;
    logic [6:0]  sc;
    int          v0;
    int          l0;

    vecs[0] = '{query: 32'h1B2C3D4E, db: 32'hFF00AA55, score: 7'h5A, hold: 0,
                exp_q: 32'h1B2C3D4E, exp_db: 32'hFF00AA55, exp_chunks: 8'h5A};
    vecs[1] = '{query: 32'h00000000, db: 32'hFFFFFFFF, score: 7'h7F, hold: 2,
                exp_q: 32'h00000000, exp_db: 32'hFFFFFFFF, exp_chunks: 8'h7F};
    vecs[2] = '{query: 32'hDEADBEEF, db: 32'h01234567, score: 7'h00, hold: 1,
                exp_q: 32'hDEADBEEF, exp_db: 32'h01234567, exp_chunks: 8'h00};
    vecs[3] = '{query: 32'h80000001, db: 32'h7FFFFFFE, score: 7'h41, hold: 0,
                exp_q: 32'h80000001, exp_db: 32'h7FFFFFFE, exp_chunks: 8'h41};

    bus_if.pad_valid = 1'b0;
    bus_if.pad_query = 8'h00;
    bus_if.pad_db = 8'h00;
    bus_if.pad_parity = 1'b0;
    bus_if.core_ready = 1'b1;
    bus_if.core_score_valid = 1'b0;
    bus_if.core_score = 7'h00;
    bus_if.err_clr = 1'b0;

    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("post_reset");

    // Table-driven transactions.
    for (int i = 0; i < 4; i++) begin
      load_word(vecs[i].query, vecs[i].db);
      launch(vecs[i].exp_q, vecs[i].exp_db, vecs[i].hold, 1'b0);
      drain(vecs[i].score, vecs[i].exp_chunks, i % 2);
    end

    // ARMED hold with overrun beats and clear/set collision.
    load_word(32'h0BADF00D, 32'h12345678);
    check("hold_busy", 64'(bus_if.pad_busy), 64'd1);
    bus_if.core_ready = 1'b0;
    v0 = cnt_start;
    tick();
    send_beat(8'h99, 8'h66, 1'b0);
    check("ovr_set", 64'(bus_if.err_overrun), 64'd1);
    check("ovr_query_kept", 64'(bus_if.core_query), 64'h0BADF00D);
    check("ovr_db_kept", 64'(bus_if.core_db), 64'h12345678);
    repeat (2) tick();
    bus_if.err_clr = 1'b1;
    send_beat(8'h77, 8'h11, 1'b0);
    check("ovr_set_wins", 64'(bus_if.err_overrun), 64'd1);
    tick();
    bus_if.err_clr = 1'b0;
    check("ovr_cleared", 64'(bus_if.err_overrun), 64'd0);
    repeat (4) tick();
    check("hold10_no_start", 64'(cnt_start - v0), 64'd0);
    check("hold10_query", 64'(bus_if.core_query), 64'h0BADF00D);
    bus_if.core_ready = 1'b1;
    tick();
    check("hold10_start", 64'(bus_if.core_start), 64'd1);
    tick();
    check("hold10_start_off", 64'(bus_if.core_start), 64'd0);
    drain(7'h2B, 8'h2B, 2);

    // Reset after two beats discards the partial sequence.
    send_beat(8'hAA, 8'h55, 1'b0);
    send_beat(8'hBB, 8'h66, 1'b0);
    rst = 1'b1;
    #2;
    check_zero("rst_partial");
    tick();
    rst = 1'b0;
    tick();
    load_word(32'hC0FFEE11, 32'h22334455);
    launch(32'hC0FFEE11, 32'h22334455, 0, 1'b0);
    drain(7'h33, 8'h33, 0);

    // Reset in the middle of DRAIN.
    load_word(32'h13579BDF, 32'h2468ACE0);
    launch(32'h13579BDF, 32'h2468ACE0, 0, 1'b0);
    bus_if.core_score = 7'h6C;
    bus_if.core_score_valid = 1'b1;
    tick();
    bus_if.core_score_valid = 1'b0;
    check("mid_drain_valid", 64'(bus_if.pad_out_valid), 64'd1);
    check("mid_drain_chunk0", 64'(bus_if.pad_out_data), 64'h6);
    rst = 1'b1;
    #2;
    check_zero("rst_drain");
    v0 = cnt_valid;
    l0 = cnt_last;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_drain_no_valid", 64'(cnt_valid - v0), 64'd0);
    check("rst_drain_no_last", 64'(cnt_last - l0), 64'd0);
    load_word(32'hFEDCBA98, 32'h76543210);
    launch(32'hFEDCBA98, 32'h76543210, 0, 1'b0);
    drain(7'h15, 8'h15, 1);

    // Bad parity on the third beat.
    send_beat(8'h11, 8'h22, 1'b0);
    send_beat(8'h33, 8'h44, 1'b0);
    send_beat(8'h55, 8'h66, 1'b1);
`ifdef SW_IO_PARITY_EN
    check("par_err_set", 64'(bus_if.err_parity), 64'd1);
    check("par_busy_low", 64'(bus_if.pad_busy), 64'd0);
    send_beat(8'hA1, 8'h5E, 1'b0);
    send_beat(8'hB2, 8'h6F, 1'b0);
    send_beat(8'hC3, 8'h70, 1'b0);
    check("par_three_not_armed", 64'(bus_if.pad_busy), 64'd0);
    send_beat(8'hD4, 8'h81, 1'b0);
    check("par_err_sticky", 64'(bus_if.err_parity), 64'd1);
    launch(32'hA1B2C3D4, 32'h5E6F7081, 0, 1'b0);
    bus_if.err_clr = 1'b1;
    tick();
    bus_if.err_clr = 1'b0;
    check("par_err_cleared", 64'(bus_if.err_parity), 64'd0);
    drain(7'h4D, 8'h4D, 0);
`else
    check("nopar_err", 64'(bus_if.err_parity), 64'd0);
    send_beat(8'h77, 8'h88, 1'b0);
    check("nopar_err_after", 64'(bus_if.err_parity), 64'd0);
    launch(32'h11335577, 32'h22446688, 0, 1'b0);
    drain(7'h4D, 8'h4D, 0);
`endif

    // Randomized transactions against the reference model.
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        bus_if.core_score_valid = 1'($urandom_range(0, 1));
        bus_if.core_score = 7'($urandom);
        tick();
      end
      bus_if.core_score_valid = 1'b0;
      eq = 32'h0;
      ed = 32'h0;
      for (int b = 0; b < 4; b++) begin
        bq = 8'($urandom);
        bd = 8'($urandom);
        eq = (eq << 8) | 32'(bq);
        ed = (ed << 8) | 32'(bd);
        send_beat(bq, bd, 1'b0);
      end
      launch(eq, ed, int'($urandom_range(0, 3)), 1'b1);
      sc = 7'($urandom);
      drain(sc, model_chunks(int'(sc)), int'($urandom_range(0, 3)));
      check("rand_no_overrun", 64'(bus_if.err_overrun), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
